mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS core. It replaces the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over shared memory with a req/ready handshake.
- Adds illegal-opcode detection, a memory-wait timeout and a retired-instruction counter.
- Sits between the IR/datapath and the ALU, register file and unified memory port.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready per access. 0 disables the timeout.
- TO_W, 8: width of the wait counter. Must satisfy MEM_TIMEOUT < 2^TO_W.
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- op  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- equal  in  1  combinational ALU equality of rs/rt, valid in EXEC
- mem_ready  in  1  memory completed current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe qualifying mem_req
- IorD  out  1  0 = address from PC, 1 = address from ALU_out
- IRWr  out  1  latch instruction word
- PCWr  out  1  PC write enable
- PCSrc  out  3  000 PC+4, 001 R[rs], 010 BEQ target, 011 BNE target, 100 jump target
- RegDst  out  1  1 = rd, 0 = rt
- RegWr  out  1  register file write enable
- ExtOp  out  1  1 = sign extend, 0 = zero extend
- ALUSrc  out  1  1 = immediate, 0 = R[rt]
- ALUCtr  out  6  ALU operation code
- MemtoReg  out  1  1 = memory data register, 0 = ALU_out
- state  out  3  current state
- exc  out  1  sticky exception flag
- exc_code  out  2  00 none, 01 illegal instruction, 10 memory timeout
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  count of retired instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7.
- Output timing: state is registered. All control outputs are combinational functions of state, op, funct, equal and mem_ready. Strobe defaults are 0. ALUCtr defaults to 6'b111111.
- Reset, applied on the clock edge:
  - state=FETCH, wait counter=0, exc=0, exc_code=0, instret=0.
  - While rst=1, every strobe is forced to 0: mem_req, PCWr, IRWr, RegWr, mem_we, retire.
- FETCH:
  - mem_req=1, IorD=0.
  - On mem_ready: IRWr=1, PCWr=1, PCSrc=000, next state DECODE.
- DECODE:
  - Legal set: R-type ADD ADDU SUB SUBU SLT SLTU AND OR XOR NOR SLL SRL SRA SLLV SRLV SRAV JR; I-type ADDI ADDIU SLTI SLTIU ANDI ORI XORI LW SW BEQ BNE; J.
  - Any other op/funct: next ERR, exc_code=01.
  - J: PCWr=1, PCSrc=100, retire, next FETCH.
  - All other legal instructions: next EXEC.
- EXEC:
  - ALUCtr = funct for R-type, op for I-type ALU ops, 100000 for LW/SW, 100010 for BEQ/BNE.
  - ExtOp=1 for ADDI, SLTI, LW, SW, BEQ, BNE.
  - ALUSrc=1 for I-type except BEQ/BNE.
  - JR: PCWr=1, PCSrc=001, retire, next FETCH.
  - BEQ: PCWr=equal, PCSrc=010, retire, next FETCH.
  - BNE: PCWr=!equal, PCSrc=011, retire, next FETCH.
  - LW/SW: next MEM.
  - Others: next WB.
- MEM:
  - mem_req=1, IorD=1, mem_we=1 for SW.
  - On mem_ready: SW retires and goes to FETCH. LW goes to WB.
- WB:
  - RegWr=1 for one cycle, RegDst=1 for R-type else 0, MemtoReg=1 for LW.
  - retire, next FETCH.
- Wait counter:
  - Increments each FETCH/MEM cycle with mem_ready=0. Clears on mem_ready or state change.
  - If MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT-1 with mem_ready=0: next ERR, exc_code=10.
  - mem_ready on that same cycle wins; no error is raised.
- ERR:
  - All strobes 0, exc=1. Held until rst.
- retire=1 increments instret on the same edge. instret wraps modulo 2^CNT_W.
- rst mid-instruction abandons the instruction. No RegWr or mem_we is issued in that reset cycle.

Optional Feature:
- Macro: MC_CTRL_LINK_EN.
- With the macro defined:
  - JAL (op 000011) and JALR (funct 001001) are legal.
  - JAL: in DECODE, PCWr=1, PCSrc=100, next WB. In WB, RegWr=1 with link_sel=1, writing PC+4 to $31.
  - JALR: in EXEC, PCWr=1, PCSrc=001, next WB. In WB, RegWr=1, RegDst=1, link_sel=1.
  - Adds output link_sel (1 bit). It is 0 in all other cases.
- Without the macro: both encodings are illegal (exc_code=01) and link_sel does not exist.

Test Plan:
- ADD ($1=5, $2=7, rd=$3) with mem_ready=1 in FETCH -> states 0,1,2,4,0; ALUCtr=100000 in EXEC; RegWr=1 and RegDst=1 in WB; instret=1.
- BEQ with equal=1, then BNE with equal=1 -> BEQ: PCWr=1, PCSrc=010, 3 cycles total. BNE: PCWr=0 in EXEC, instret=2.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req held for 4 cycles with IorD=1; MemtoReg=1 in WB; SW variant shows mem_we=1 and no WB.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> ERR after 4 cycles, exc=1, exc_code=10, no further strobes; rst returns to FETCH with exc=0.
- op=6'b111111 -> ERR from DECODE with exc_code=01; rst asserted mid-MEM on SW -> mem_we=0 that cycle, state=FETCH next.
- MC_CTRL_LINK_EN defined, JAL -> PCSrc=100 in DECODE; RegWr=1 and link_sel=1 in WB. Without the macro, the same JAL -> exc_code=01.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Unified memory port between the multi-cycle controller and shared memory.
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output IorD, input mem_ready);
  modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// shared memory port, with illegal-opcode trap, memory-wait timeout and a
// retired-instruction counter.
// Optional: define MC_CTRL_LINK_EN to add JAL/JALR and the link_sel output.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             equal,
  mc_ctrl_if.master        mem,
  output logic             IRWr,
  output logic             PCWr,
  output logic [2:0]       PCSrc,
  output logic             RegDst,
  output logic             RegWr,
  output logic             ExtOp,
  output logic             ALUSrc,
  output logic [5:0]       ALUCtr,
  output logic             MemtoReg,
  output logic [2:0]       state,
  output logic             exc,
  output logic [1:0]       exc_code,
  output logic             retire,
  output logic [CNT_W-1:0] instret
`ifdef MC_CTRL_LINK_EN
  ,
  output logic             link_sel
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             exc_q;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] instret_q;

  logic is_r, is_jr, is_j, is_lw, is_sw, is_beq, is_bne, is_ialu, legal;
  logic mem_req_c, mem_we_c, irwr_c, pcwr_c, regwr_c, retire_c, to_hit;
`ifdef MC_CTRL_LINK_EN
  logic is_jal, is_jalr, link_c;
`endif

  // Instruction classification from the IR opcode/function fields.
  always_comb begin
    is_r    = (op == 6'b000000);
    is_jr   = is_r && (funct == 6'b001000);
    is_j    = (op == 6'b000010);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_beq  = (op == 6'b000100);
    is_bne  = (op == 6'b000101);
    is_ialu = (op >= 6'b001000) && (op <= 6'b001110);
    legal   = is_j || is_lw || is_sw || is_beq || is_bne || is_ialu;
    if (is_r) begin
      case (funct)
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b101010, 6'b101011,
        6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b000000, 6'b000010,
        6'b000011, 6'b000100, 6'b000110, 6'b000111, 6'b001000: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
`ifdef MC_CTRL_LINK_EN
    is_jal  = (op == 6'b000011);
    is_jalr = is_r && (funct == 6'b001001);
    if (is_jal || is_jalr) legal = 1'b1;
`endif
  end

  assign to_hit = (MEM_TIMEOUT != 0) && (wait_q == TO_LAST);

  // Next-state and control decode for the current state.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    code_d    = code_q;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    mem.IorD  = 1'b0;
    irwr_c    = 1'b0;
    pcwr_c    = 1'b0;
    PCSrc     = 3'b000;
    RegDst    = 1'b0;
    regwr_c   = 1'b0;
    ExtOp     = 1'b0;
    ALUSrc    = 1'b0;
    ALUCtr    = '1;
    MemtoReg  = 1'b0;
    retire_c  = 1'b0;
`ifdef MC_CTRL_LINK_EN
    link_c    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem.mem_ready) begin
          irwr_c  = 1'b1;
          pcwr_c  = 1'b1;
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_ERR;
          code_d  = 2'b10;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (!legal) begin
          state_d = S_ERR;
          code_d  = 2'b01;
        end else if (is_j) begin
          pcwr_c   = 1'b1;
          PCSrc    = 3'b100;
          retire_c = 1'b1;
          state_d  = S_FETCH;
`ifdef MC_CTRL_LINK_EN
        end else if (is_jal) begin
          pcwr_c  = 1'b1;
          PCSrc   = 3'b100;
          state_d = S_WB;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r)                ALUCtr = funct;
        else if (is_ialu)        ALUCtr = op;
        else if (is_lw || is_sw) ALUCtr = 6'b100000;
        else                     ALUCtr = 6'b100010;
        ExtOp  = (op == 6'b001000) || (op == 6'b001010) || is_lw || is_sw
                 || is_beq || is_bne;
        ALUSrc = is_ialu || is_lw || is_sw;
        state_d = S_WB;
        if (is_jr) begin
          pcwr_c   = 1'b1;
          PCSrc    = 3'b001;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_beq) begin
          pcwr_c   = equal;
          PCSrc    = 3'b010;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_bne) begin
          pcwr_c   = !equal;
          PCSrc    = 3'b011;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
`ifdef MC_CTRL_LINK_EN
        end else if (is_jalr) begin
          pcwr_c = 1'b1;
          PCSrc  = 3'b001;
`endif
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem.IorD  = 1'b1;
        mem_we_c  = is_sw;
        if (mem.mem_ready) begin
          retire_c = is_sw;
          state_d  = is_sw ? S_FETCH : S_WB;
        end else if (to_hit) begin
          state_d = S_ERR;
          code_d  = 2'b10;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        regwr_c  = 1'b1;
        RegDst   = is_r;
        MemtoReg = is_lw;
        retire_c = 1'b1;
        state_d  = S_FETCH;
`ifdef MC_CTRL_LINK_EN
        link_c   = is_jal || is_jalr;
`endif
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Strobes are suppressed combinationally while reset is held.
  assign mem.mem_req = mem_req_c & ~rst;
  assign mem.mem_we  = mem_we_c  & ~rst;
  assign IRWr        = irwr_c    & ~rst;
  assign PCWr        = pcwr_c    & ~rst;
  assign RegWr       = regwr_c   & ~rst;
  assign retire      = retire_c  & ~rst;
`ifdef MC_CTRL_LINK_EN
  assign link_sel    = link_c;
`endif
  assign state    = state_q;
  assign exc      = exc_q;
  assign exc_code = code_q;
  assign instret  = instret_q;

  // State, wait counter, exception status and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      exc_q     <= 1'b0;
      code_q    <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      exc_q   <= (state_d == S_ERR);
      code_q  <= code_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl built with MEM_TIMEOUT=4.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, funct;
  logic        equal;
  logic        IRWr, PCWr, RegDst, RegWr, ExtOp, ALUSrc, MemtoReg, exc, retire;
  logic [2:0]  PCSrc, state;
  logic [5:0]  ALUCtr;
  logic [1:0]  exc_code;
  logic [31:0] instret;
`ifdef MC_CTRL_LINK_EN
  logic        link_sel;
`endif

  logic        rst_v = 1'b1;
  logic [5:0]  op_v = '0, fn_v = '0;
  int          n_assert = 0;
  int          n_fail = 0;

  mc_ctrl_if mem_if ();

  mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .equal(equal), .mem(mem_if.master),
    .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr),
    .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUCtr(ALUCtr), .MemtoReg(MemtoReg),
    .state(state), .exc(exc), .exc_code(exc_code), .retire(retire), .instret(instret)
`ifdef MC_CTRL_LINK_EN
    , .link_sel(link_sel)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle, then let checks run.
  task automatic drive(input logic eq, input logic rdy);
    @(negedge clk);
    rst = rst_v; op = op_v; funct = fn_v; equal = eq; mem_if.mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    chk("rst_state", state, 0);
    chk("rst_exc", exc, 0);
    chk("rst_code", exc_code, 0);
    chk("rst_instret", instret, 0);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_irwr", IRWr, 0);
    chk("rst_pcwr", PCWr, 0);
    rst_v = 1'b0;
  endtask

  task automatic fetch(input logic [5:0] o, input logic [5:0] f);
    op_v = o; fn_v = f;
    drive(1'b0, 1'b1);
    chk("fetch_state", state, 0);
    chk("fetch_req", mem_if.mem_req, 1);
    chk("fetch_iord", mem_if.IorD, 0);
    chk("fetch_irwr", IRWr, 1);
    chk("fetch_pcsrc", PCSrc, 0);
    drive(1'b0, 1'b0);
    chk("decode_state", state, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // ADD $3,$1,$2
    fetch(6'b000000, 6'b100000);
    chk("add_dec_req", mem_if.mem_req, 0);
    drive(1'b0, 1'b0);
    chk("add_exec_state", state, 2);
    chk("add_aluctr", ALUCtr, 6'b100000);
    chk("add_alusrc", ALUSrc, 0);
    drive(1'b0, 1'b0);
    chk("add_wb_state", state, 4);
    chk("add_regwr", RegWr, 1);
    chk("add_regdst", RegDst, 1);
    chk("add_retire", retire, 1);

    // BEQ taken
    fetch(6'b000100, 6'b000000);
    chk("add_instret", instret, 1);
    drive(1'b1, 1'b0);
    chk("beq_state", state, 2);
    chk("beq_pcwr", PCWr, 1);
    chk("beq_pcsrc", PCSrc, 3'b010);
    chk("beq_aluctr", ALUCtr, 6'b100010);
    chk("beq_extop", ExtOp, 1);
    chk("beq_retire", retire, 1);

    // BNE with equal=1: not taken
    fetch(6'b000101, 6'b000000);
    drive(1'b1, 1'b0);
    chk("bne_pcwr", PCWr, 0);
    chk("bne_pcsrc", PCSrc, 3'b011);
    chk("bne_retire", retire, 1);

    // LW with three wait cycles
    fetch(6'b100011, 6'b000000);
    chk("bne_instret", instret, 3);
    drive(1'b0, 1'b0);
    chk("lw_aluctr", ALUCtr, 6'b100000);
    chk("lw_alusrc", ALUSrc, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      chk("lw_mem_state", state, 3);
      chk("lw_mem_req", mem_if.mem_req, 1);
      chk("lw_mem_iord", mem_if.IorD, 1);
    end
    drive(1'b0, 1'b1);
    chk("lw_mem4_req", mem_if.mem_req, 1);
    chk("lw_mem_we", mem_if.mem_we, 0);
    drive(1'b0, 1'b0);
    chk("lw_wb_state", state, 4);
    chk("lw_memtoreg", MemtoReg, 1);
    chk("lw_regdst", RegDst, 0);
    chk("lw_regwr", RegWr, 1);

    // SW retires from MEM
    fetch(6'b101011, 6'b000000);
    chk("lw_instret", instret, 4);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    chk("sw_mem_we", mem_if.mem_we, 1);
    chk("sw_retire", retire, 1);

    // J retires from DECODE
    op_v = 6'b000010; fn_v = '0;
    drive(1'b0, 1'b1);
    chk("sw_next_state", state, 0);
    chk("sw_instret", instret, 5);
    drive(1'b0, 1'b0);
    chk("j_pcwr", PCWr, 1);
    chk("j_pcsrc", PCSrc, 3'b100);
    chk("j_retire", retire, 1);

    // JR
    fetch(6'b000000, 6'b001000);
    drive(1'b0, 1'b0);
    chk("jr_pcsrc", PCSrc, 3'b001);
    chk("jr_pcwr", PCWr, 1);

    // ORI: zero-extended immediate
    fetch(6'b001101, 6'b000000);
    drive(1'b0, 1'b0);
    chk("ori_aluctr", ALUCtr, 6'b001101);
    chk("ori_extop", ExtOp, 0);
    chk("ori_alusrc", ALUSrc, 1);
    drive(1'b0, 1'b0);
    chk("ori_regdst", RegDst, 0);

    // Illegal opcode
    fetch(6'b111111, 6'b000000);
    chk("ori_instret", instret, 8);
    drive(1'b0, 1'b1);
    chk("ill_state", state, 7);
    chk("ill_exc", exc, 1);
    chk("ill_code", exc_code, 2'b01);
    chk("ill_req", mem_if.mem_req, 0);
    drive(1'b0, 1'b1);
    chk("ill_hold", state, 7);

    // FETCH timeout after four unanswered cycles
    do_reset();
    op_v = '0; fn_v = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      chk("to_wait_state", state, 0);
    end
    drive(1'b0, 1'b1);
    chk("to_state", state, 7);
    chk("to_exc", exc, 1);
    chk("to_code", exc_code, 2'b10);
    chk("to_req", mem_if.mem_req, 0);
    chk("to_irwr", IRWr, 0);

    // Reset during SW memory access
    do_reset();
    fetch(6'b101011, 6'b000000);
    drive(1'b0, 1'b0);
    rst_v = 1'b1;
    drive(1'b0, 1'b1);
    chk("rmid_state", state, 3);
    chk("rmid_we", mem_if.mem_we, 0);
    chk("rmid_retire", retire, 0);
    rst_v = 1'b0;
    drive(1'b0, 1'b0);
    chk("rmid_next", state, 0);
    chk("rmid_instret", instret, 0);

    // JAL
    fetch(6'b000011, 6'b000000);
`ifdef MC_CTRL_LINK_EN
    chk("jal_pcwr", PCWr, 1);
    chk("jal_pcsrc", PCSrc, 3'b100);
    chk("jal_noretire", retire, 0);
    drive(1'b0, 1'b0);
    chk("jal_wb_state", state, 4);
    chk("jal_regwr", RegWr, 1);
    chk("jal_link", link_sel, 1);
    drive(1'b0, 1'b0);
    chk("jal_instret", instret, 1);
`else
    chk("jal_pcwr", PCWr, 0);
    drive(1'b0, 1'b0);
    chk("jal_state", state, 7);
    chk("jal_code", exc_code, 2'b01);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
